// File: rtl/snake_control.sv
// Sequencing FSM for the snake datapath: body RAM init, tick pacing, shift, tail erase and 2x2 redraw.
// All datapath strobes are decoded from the state; only the first-plot collision abort looks at isDead.
module snake_control #(
    parameter int LEN         = 8,
    parameter int TICK_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       isDead,
    output logic       ld_head,
    output logic       ld_q_def,
    output logic       inc_address,
    output logic       rst_address,
    output logic       draw_q,
    output logic       update_head,
    output logic       ld_head_into_prev,
    output logic       ld_q_into_curr,
    output logic       ld_prev_into_q,
    output logic       ld_curr_into_prev,
    output logic       draw_curr,
    output logic [1:0] cnt_status,
    output logic [2:0] colour,
    output logic       busy,
    output logic       dead
);

    localparam int SW = $clog2(LEN);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [SW-1:0] SEG_LAST  = SW'(LEN - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_HEAD,
        S_INIT_Q,
        S_DR_READ,
        S_DR_PLOT,
        S_WAIT,
        S_MOVE,
        S_SH_READ,
        S_SH_SWAP,
        S_SH_NEXT,
        S_ERASE,
        S_DEAD
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   seg;
    logic [1:0]      phase;
    logic [TW-1:0]   tick_cnt;
    logic            tick_wrap;
    logic            tick_pending;
    logic            tick_take;
    logic            seg_last;

    assign seg_last  = (seg == SEG_LAST);
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign tick_take = (state == S_WAIT) && tick_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // seg shadows the datapath RAM address so the FSM knows when the body ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
        end else if (rst_address) begin
            seg <= '0;
        end else if (inc_address) begin
            seg <= seg + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
        end else if (state == S_DR_PLOT || state == S_ERASE) begin
            phase <= phase + 2'd1;
        end else begin
            phase <= 2'd0;
        end
    end

    // A wrap landing on the same edge as the WAIT->MOVE hand-off is a fresh tick and survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            if (tick_wrap) begin
                tick_pending <= 1'b1;
            end else if (tick_take) begin
                tick_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        draw_q            = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        draw_curr         = 1'b0;
        cnt_status        = 2'd0;
        dead              = 1'b0;
        case (state)
            S_IDLE: begin
                rst_address = 1'b1;
                if (start) state_nxt = S_INIT_HEAD;
            end
            S_INIT_HEAD: begin
                ld_head     = 1'b1;
                rst_address = 1'b1;
                state_nxt   = S_INIT_Q;
            end
            S_INIT_Q: begin
                ld_q_def = 1'b1;
                if (seg_last) begin
                    rst_address = 1'b1;
                    state_nxt   = S_DR_READ;
                end else begin
                    inc_address = 1'b1;
                end
            end
            S_DR_READ: begin
                state_nxt = S_DR_PLOT;
            end
            S_DR_PLOT: begin
                cnt_status = phase;
                if (phase == 2'd0 && isDead) begin
                    state_nxt = S_DEAD;
                end else begin
                    draw_q = 1'b1;
                    if (phase == 2'd3) begin
                        if (seg_last) begin
                            rst_address = 1'b1;
                            state_nxt   = S_WAIT;
                        end else begin
                            inc_address = 1'b1;
                            state_nxt   = S_DR_READ;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (tick_pending) state_nxt = S_MOVE;
            end
            S_MOVE: begin
                ld_head_into_prev = 1'b1;
                update_head       = 1'b1;
                state_nxt         = S_SH_READ;
            end
            S_SH_READ: begin
                state_nxt = S_SH_SWAP;
            end
            S_SH_SWAP: begin
                ld_q_into_curr = 1'b1;
                ld_prev_into_q = 1'b1;
                state_nxt      = S_SH_NEXT;
            end
            S_SH_NEXT: begin
                ld_curr_into_prev = 1'b1;
                if (seg_last) begin
                    rst_address = 1'b1;
                    state_nxt   = S_ERASE;
                end else begin
                    inc_address = 1'b1;
                    state_nxt   = S_SH_READ;
                end
            end
            S_ERASE: begin
                draw_curr  = 1'b1;
                cnt_status = phase;
                if (phase == 2'd3) state_nxt = S_DR_READ;
            end
            S_DEAD: begin
                dead = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign colour = draw_q ? 3'b010 : 3'b000;
    assign busy   = !(state == S_IDLE || state == S_WAIT || state == S_DEAD);

endmodule

// File: tb/tb_snake_control.sv
// Self-checking bench for snake_control: two instances (slow and fast tick) driven against
// expected per-cycle output sequences derived from the game phase rules.
module tb_snake_control;

    localparam int LEN_T = 4;
    localparam int TA    = 64;
    localparam int TB    = 16;

    // observed vector layout
    localparam int P_LDH = 17, P_LDQ = 16, P_INC = 15, P_RSTA = 14, P_DRQ = 13, P_UPD = 12;
    localparam int P_HIP = 11, P_QIC = 10, P_PIQ = 9, P_CIP = 8, P_DRC = 7, P_BUSY = 1;
    localparam logic [17:0] V_IDLE = 18'h1 << 14;
    localparam logic [17:0] V_WAIT = 18'h0;
    localparam logic [17:0] V_DEAD = 18'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, start_a = 1'b0, isDead_a = 1'b0;
    logic rst_b = 1'b1, start_b = 1'b0, isDead_b = 1'b0;

    logic ld_head_a, ld_q_def_a, inc_address_a, rst_address_a, draw_q_a, update_head_a;
    logic ld_head_into_prev_a, ld_q_into_curr_a, ld_prev_into_q_a, ld_curr_into_prev_a, draw_curr_a;
    logic [1:0] cnt_status_a;
    logic [2:0] colour_a;
    logic busy_a, dead_a;
    logic ld_head_b, ld_q_def_b, inc_address_b, rst_address_b, draw_q_b, update_head_b;
    logic ld_head_into_prev_b, ld_q_into_curr_b, ld_prev_into_q_b, ld_curr_into_prev_b, draw_curr_b;
    logic [1:0] cnt_status_b;
    logic [2:0] colour_b;
    logic busy_b, dead_b;

    snake_control #(.LEN(LEN_T), .TICK_CYCLES(TA)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .isDead(isDead_a),
        .ld_head(ld_head_a), .ld_q_def(ld_q_def_a), .inc_address(inc_address_a),
        .rst_address(rst_address_a), .draw_q(draw_q_a), .update_head(update_head_a),
        .ld_head_into_prev(ld_head_into_prev_a), .ld_q_into_curr(ld_q_into_curr_a),
        .ld_prev_into_q(ld_prev_into_q_a), .ld_curr_into_prev(ld_curr_into_prev_a),
        .draw_curr(draw_curr_a), .cnt_status(cnt_status_a), .colour(colour_a),
        .busy(busy_a), .dead(dead_a)
    );

    snake_control #(.LEN(LEN_T), .TICK_CYCLES(TB)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .isDead(isDead_b),
        .ld_head(ld_head_b), .ld_q_def(ld_q_def_b), .inc_address(inc_address_b),
        .rst_address(rst_address_b), .draw_q(draw_q_b), .update_head(update_head_b),
        .ld_head_into_prev(ld_head_into_prev_b), .ld_q_into_curr(ld_q_into_curr_b),
        .ld_prev_into_q(ld_prev_into_q_b), .ld_curr_into_prev(ld_curr_into_prev_b),
        .draw_curr(draw_curr_b), .cnt_status(cnt_status_b), .colour(colour_b),
        .busy(busy_b), .dead(dead_b)
    );

    logic [17:0] obs_a, obs_b;
    assign obs_a = {ld_head_a, ld_q_def_a, inc_address_a, rst_address_a, draw_q_a, update_head_a,
                    ld_head_into_prev_a, ld_q_into_curr_a, ld_prev_into_q_a, ld_curr_into_prev_a,
                    draw_curr_a, cnt_status_a, colour_a, busy_a, dead_a};
    assign obs_b = {ld_head_b, ld_q_def_b, inc_address_b, rst_address_b, draw_q_b, update_head_b,
                    ld_head_into_prev_b, ld_q_into_curr_b, ld_prev_into_q_b, ld_curr_into_prev_b,
                    draw_curr_b, cnt_status_b, colour_b, busy_b, dead_b};

    int checks = 0;
    int errors = 0;
    int ecnt_a = 0;
    int next_tick = TA;

    // clock edges since dut_a left reset; its tick wraps on every multiple of TA
    always @(posedge clk) begin
        if (rst_a) ecnt_a <= 0;
        else       ecnt_a <= ecnt_a + 1;
    end

    always @(negedge clk) begin
        checks = checks + 2;
        if ((inc_address_a & rst_address_a) !== 1'b0 || (inc_address_b & rst_address_b) !== 1'b0) begin
            errors++;
            $display("FAIL addr_excl got a=%b%b b=%b%b want no overlap", inc_address_a, rst_address_a,
                     inc_address_b, rst_address_b);
        end
        if ((ld_head_a & update_head_a) !== 1'b0 || (ld_head_b & update_head_b) !== 1'b0) begin
            errors++;
            $display("FAIL head_excl got a=%b%b b=%b%b want no overlap", ld_head_a, update_head_a,
                     ld_head_b, update_head_b);
        end
    end

    // ---------------- reference model: expected cycle sequences ----------------
    // dm: 0 = isDead don't-care (randomised), 1 = must be 0 (sampled, no collision), 2 = force 1
    typedef struct {
        logic [17:0] v;
        int          dm;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [17:0] one(input int pos);
        return 18'h1 << pos;
    endfunction

    function automatic logic [17:0] plot_v(input int p, input bit erase);
        logic [17:0] v;
        v = one(P_BUSY) | (18'(p) << 5);
        if (erase) v = v | one(P_DRC);
        else       v = v | one(P_DRQ) | (18'h2 << 2);
        return v;
    endfunction

    function automatic void push(input logic [17:0] v, input int dm);
        exp_t e;
        e.v  = v;
        e.dm = dm;
        exp_q.push_back(e);
    endfunction

    // address step at the end of a per-segment pass: advance, or rewind after the last segment
    function automatic logic [17:0] step(input int s);
        return (s < LEN_T - 1) ? one(P_INC) : one(P_RSTA);
    endfunction

    function automatic void push_draw();
        for (int s = 0; s < LEN_T; s++) begin
            push(one(P_BUSY), 0);
            for (int p = 0; p < 4; p++)
                push(plot_v(p, 1'b0) | ((p == 3) ? step(s) : 18'h0), (p == 0) ? 1 : 0);
        end
    endfunction

    function automatic void push_init();
        exp_q.delete();
        push(one(P_LDH) | one(P_RSTA) | one(P_BUSY), 0);
        for (int k = 0; k < LEN_T; k++) push(one(P_LDQ) | one(P_BUSY) | step(k), 0);
        push_draw();
    endfunction

    function automatic void push_move();
        exp_q.delete();
        push(one(P_HIP) | one(P_UPD) | one(P_BUSY), 0);
        for (int s = 0; s < LEN_T; s++) begin
            push(one(P_BUSY), 0);
            push(one(P_QIC) | one(P_PIQ) | one(P_BUSY), 0);
            push(one(P_CIP) | one(P_BUSY) | step(s), 0);
        end
        for (int p = 0; p < 4; p++) push(plot_v(p, 1'b1), 0);
        push_draw();
    endfunction

    function automatic logic dead_in(input int dm);
        if (dm == 1) return 1'b0;
        if (dm == 2) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) begin
            @(posedge clk); #1 start_a = 1'b1; isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_a !== V_IDLE) begin
                errors++; $display("FAIL reset_outputs got %h want %h", obs_a, V_IDLE);
            end
            checks++;
            if (dut_a.seg !== 2'd0) begin
                errors++; $display("FAIL reset_seg got %0d want 0", dut_a.seg);
            end
        end
        @(posedge clk); #1 rst_a = 1'b0; start_a = 1'b0;
    endtask

    task automatic test_init();
        int r;
        r = $urandom_range(1, 6);
        repeat (r) begin
            @(posedge clk); #1 start_a = 1'b0; isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_a !== V_IDLE) begin
                errors++; $display("FAIL idle_hold got %h want %h", obs_a, V_IDLE);
            end
        end
        @(posedge clk); #1 start_a = 1'b1;
        push_init();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1 start_a = 1'($urandom_range(0, 1)); isDead_a = dead_in(exp_q[i].dm);
            @(negedge clk);
            checks++;
            if (obs_a !== exp_q[i].v) begin
                errors++; $display("FAIL init_seq cyc %0d got %h want %h", i, obs_a, exp_q[i].v);
            end
        end
        start_a = 1'b0;
        next_tick = TA;
    endtask

    task automatic test_tick_move();
        int guard = 0;
        while (ecnt_a < next_tick && guard < 300) begin
            @(posedge clk); #1 start_a = 1'($urandom_range(0, 1)); isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
            checks++;
            if (obs_a !== V_WAIT) begin
                errors++; $display("FAIL wait_idle edge %0d got %h want %h", ecnt_a, obs_a, V_WAIT);
            end
        end
        checks++;
        if (guard >= 300) begin
            errors++; $display("FAIL wait_timeout got %0d cycles want tick at edge %0d", guard, next_tick);
        end
        push_move();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1 start_a = 1'($urandom_range(0, 1)); isDead_a = dead_in(exp_q[i].dm);
            @(negedge clk);
            checks++;
            if (obs_a !== exp_q[i].v) begin
                errors++; $display("FAIL move_seq cyc %0d got %h want %h", i, obs_a, exp_q[i].v);
            end
        end
        start_a = 1'b0;
        next_tick += TA;
    endtask

    task automatic test_dead();
        int guard = 0;
        while (ecnt_a < next_tick && guard < 300) begin
            @(posedge clk); #1 isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
            checks++;
            if (obs_a !== V_WAIT) begin
                errors++; $display("FAIL dead_wait edge %0d got %h want %h", ecnt_a, obs_a, V_WAIT);
            end
        end
        push_move();
        // cut at the third redraw segment's first plot cycle (MOVE + 12 shift + 4 erase + 2*5 + read)
        while (exp_q.size() > 28) void'(exp_q.pop_back());
        push(one(P_BUSY), 2);
        push(V_DEAD, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1 isDead_a = dead_in(exp_q[i].dm);
            @(negedge clk);
            checks++;
            if (obs_a !== exp_q[i].v) begin
                errors++; $display("FAIL dead_entry cyc %0d got %h want %h", i, obs_a, exp_q[i].v);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1 start_a = 1'($urandom_range(0, 1)); isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs_a !== V_DEAD) begin
                errors++; $display("FAIL dead_hold cyc %0d got %h want %h", i, obs_a, V_DEAD);
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_rst_mid_shift();
        int k;
        int guard = 0;
        #1 rst_a = 1'b1;
        #1;
        checks++;
        if (obs_a !== V_IDLE) begin
            errors++; $display("FAIL rst_from_dead got %h want %h", obs_a, V_IDLE);
        end
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        test_init();
        while (ecnt_a < next_tick && guard < 300) begin
            @(posedge clk); #1 isDead_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        k = $urandom_range(0, LEN_T - 1);
        push_move();
        for (int i = 0; i <= 2 + 3 * k; i++) begin
            @(posedge clk); #1 isDead_a = dead_in(exp_q[i].dm);
            @(negedge clk);
            checks++;
            if (obs_a !== exp_q[i].v) begin
                errors++; $display("FAIL pre_rst_seq cyc %0d got %h want %h", i, obs_a, exp_q[i].v);
            end
        end
        #1 rst_a = 1'b1;
        #1;
        checks++;
        if (obs_a !== V_IDLE) begin
            errors++; $display("FAIL rst_in_swap seg %0d got %h want %h", k, obs_a, V_IDLE);
        end
        checks++;
        if (dut_a.seg !== 2'd0) begin
            errors++; $display("FAIL rst_in_swap_seg got %0d want 0", dut_a.seg);
        end
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        test_init();
    endtask

    task automatic test_coalesce();
        int  guard = 0;
        int  moves = 0;
        int  waits = 0;
        int  since_move = -1;
        bit  prev_wait, cur_wait, cur_move;
        @(posedge clk); #1 rst_b = 1'b0;
        @(posedge clk); #1 start_b = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (obs_b !== V_WAIT && guard < 200);
        checks++;
        if (obs_b !== V_WAIT) begin
            errors++; $display("FAIL fast_first_wait got %h want %h", obs_b, V_WAIT);
        end
        prev_wait = 1'b1;
        waits = 1;
        repeat (400) begin
            @(negedge clk);
            cur_wait = (obs_b === V_WAIT);
            cur_move = (obs_b[P_UPD] === 1'b1);
            if (prev_wait) begin
                checks++;
                if (!cur_move) begin
                    errors++; $display("FAIL wait_then_move got %h want move", obs_b);
                end
            end
            if (cur_move) begin
                checks++;
                if (!prev_wait) begin
                    errors++; $display("FAIL move_without_wait got prev=busy want prev=wait");
                end
                moves++;
                since_move = 0;
            end else if (since_move >= 0) begin
                since_move++;
            end
            if (cur_wait && !prev_wait) begin
                waits++;
                checks++;
                if (since_move != 8 * LEN_T + 5) begin
                    errors++; $display("FAIL move_span got %0d want %0d", since_move, 8 * LEN_T + 5);
                end
            end
            prev_wait = cur_wait;
        end
        checks++;
        if (waits - moves < 0 || waits - moves > 1 || moves < 9) begin
            errors++; $display("FAIL move_count got moves=%0d waits=%0d want one move per wait", moves, waits);
        end
        start_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_tick_move();
        test_dead();
        test_rst_mid_shift();
        test_coalesce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
